// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback, with a watchdog on memory waits.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    state_t     cur;
    logic [7:0] waitcnt;
    logic       waiting;
    logic       expire;
    logic       pcwrite;
    logic       branch;

    assign waiting = (cur == FETCH) || (cur == MEMRD) || (cur == MEMWR);
    assign expire  = waiting && (TIMEOUT != 8'd0) && (waitcnt == TIMEOUT) && !mem_ready;

    // The wait counter only runs while stalled in a memory state, so it is
    // already zero on entry to any of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= FETCH;
            waitcnt <= '0;
        end else begin
            if (expire)
                waitcnt <= '0;
            else if (waiting && !mem_ready)
                waitcnt <= (waitcnt == 8'hff) ? waitcnt : waitcnt + 8'd1;
            else
                waitcnt <= '0;

            if (expire) begin
                cur <= FETCH;
            end else begin
                case (cur)
                    FETCH:   if (mem_ready) cur <= DECODE;
                    DECODE: begin
                        case (op)
                            OP_LW, OP_SW: cur <= MEMADR;
                            OP_RTYPE:     cur <= RTYPEEX;
                            OP_BEQ:       cur <= BEQEX;
                            OP_ADDI:      cur <= ADDIEX;
                            OP_J:         cur <= JEX;
                            default:      cur <= FETCH;
                        endcase
                    end
                    MEMADR:  cur <= (op == OP_SW) ? MEMWR : MEMRD;
                    MEMRD:   if (mem_ready) cur <= MEMWB;
                    MEMWR:   if (mem_ready) cur <= FETCH;
                    RTYPEEX: cur <= RTYPEWB;
                    ADDIEX:  cur <= ADDIWB;
                    default: cur <= FETCH;
                endcase
            end
        end
    end

    // Outputs follow the registered state; only mem_ready and zero qualify them.
    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        mem_err    = 1'b0;
        if (!rst) begin
            case (cur)
                FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: iord = 1'b1;
                MEMWB: begin
                    memtoreg   = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = mem_ready;
                end
                RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                RTYPEWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                BEQEX: begin
                    alusrca    = 1'b1;
                    aluop      = 2'b01;
                    pcsrc      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = 2'b11;
                end
                ADDIWB: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                JEX: begin
                    pcsrc      = 2'b10;
                    pcwrite    = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
            if (expire) begin
                mem_err  = 1'b1;
                pcwrite  = 1'b0;
                irwrite  = 1'b0;
                memwrite = 1'b0;
                regwrite = 1'b0;
            end
        end
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the selected DUT.
module tb_mc_controller;

    localparam logic [16:0] PCEN     = 17'h10000;
    localparam logic [16:0] IORD     = 17'h08000;
    localparam logic [16:0] MEMWRITE = 17'h04000;
    localparam logic [16:0] IRWRITE  = 17'h02000;
    localparam logic [16:0] REGDST   = 17'h01000;
    localparam logic [16:0] MEMTOREG = 17'h00800;
    localparam logic [16:0] REGWRITE = 17'h00400;
    localparam logic [16:0] ALUSRCA  = 17'h00200;
    localparam logic [16:0] DONE     = 17'h00004;
    localparam logic [16:0] ILLEGAL  = 17'h00002;
    localparam logic [16:0] MEMERR   = 17'h00001;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    function automatic logic [16:0] sb(input logic [1:0] v);
        return {8'b0, v, 7'b0};
    endfunction
    function automatic logic [16:0] ps(input logic [1:0] v);
        return {10'b0, v, 5'b0};
    endfunction
    function automatic logic [16:0] ao(input logic [1:0] v);
        return {12'b0, v, 3'b0};
    endfunction

    typedef struct {
        string       name;
        bit          which;
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;

    logic       a_pcen, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrca;
    logic [1:0] a_alusrcb, a_pcsrc, a_aluop;
    logic       a_done, a_illegal, a_memerr;
    logic [3:0] a_state;
    logic       b_pcen, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrca;
    logic [1:0] b_alusrcb, b_pcsrc, b_aluop;
    logic       b_done, b_illegal, b_memerr;
    logic [3:0] b_state;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(a_pcen), .iord(a_iord), .memwrite(a_memwrite), .irwrite(a_irwrite),
        .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrca(a_alusrca),
        .alusrcb(a_alusrcb), .pcsrc(a_pcsrc), .aluop(a_aluop), .instr_done(a_done),
        .illegal_op(a_illegal), .mem_err(a_memerr), .state(a_state)
    );

    mc_controller #(.MEM_TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pcen(b_pcen), .iord(b_iord), .memwrite(b_memwrite), .irwrite(b_irwrite),
        .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrca(b_alusrca),
        .alusrcb(b_alusrcb), .pcsrc(b_pcsrc), .aluop(b_aluop), .instr_done(b_done),
        .illegal_op(b_illegal), .mem_err(b_memerr), .state(b_state)
    );

    logic [16:0] a_outs, b_outs;
    assign a_outs = {a_pcen, a_iord, a_memwrite, a_irwrite, a_regdst, a_memtoreg, a_regwrite,
                     a_alusrca, a_alusrcb, a_pcsrc, a_aluop, a_done, a_illegal, a_memerr};
    assign b_outs = {b_pcen, b_iord, b_memwrite, b_irwrite, b_regdst, b_memtoreg, b_regwrite,
                     b_alusrca, b_alusrcb, b_pcsrc, b_aluop, b_done, b_illegal, b_memerr};

    task automatic checkOutput(input exp_t e);
        logic [3:0]  st;
        logic [16:0] outs;
        st   = e.which ? b_state : a_state;
        outs = e.which ? b_outs  : a_outs;
        compared++;
        if (st !== e.st || outs !== e.outs) begin
            mismatched++;
            $display("[TB] FAIL %s (dut%0d): got state=%0d outs=%05h, want state=%0d outs=%05h",
                     e.name, e.which, st, outs, e.st, e.outs);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) checkOutput(q.pop_front());
    end

    task automatic applyStimulus(input string name, input bit r, input bit which,
                                 input logic [5:0] o, input bit z, input bit rdy,
                                 input logic [3:0] st, input logic [16:0] outs);
        exp_t e;
        rst       = r;
        op        = o;
        zero      = z;
        mem_ready = rdy;
        e.name  = name;
        e.which = which;
        e.st    = st;
        e.outs  = outs;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("reset_a", 1, 0, LW, 1, 1, 4'd0, 17'h0);
        applyStimulus("reset_b", 1, 1, LW, 1, 1, 4'd0, 17'h0);

        applyStimulus("fetch_stall0", 0, 0, LW, 0, 0, 4'd0, sb(2'b01));
        applyStimulus("fetch_stall1", 0, 0, LW, 0, 0, 4'd0, sb(2'b01));

        applyStimulus("lw_fetch",  0, 0, LW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("lw_decode", 0, 0, LW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("lw_memadr", 0, 0, LW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        applyStimulus("lw_memrd",  0, 0, LW, 0, 1, 4'd3, IORD);
        applyStimulus("lw_memwb",  0, 0, LW, 0, 1, 4'd4, MEMTOREG | REGWRITE | DONE);

        applyStimulus("sw_fetch",  0, 0, SW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("sw_decode", 0, 0, SW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("sw_memadr", 0, 0, SW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        for (int i = 0; i < 3; i++)
            applyStimulus("sw_stall", 0, 0, SW, 0, 0, 4'd5, IORD | MEMWRITE);
        applyStimulus("sw_done",   0, 0, SW, 0, 1, 4'd5, IORD | MEMWRITE | DONE);

        applyStimulus("rt_fetch",  0, 0, RT, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("rt_decode", 0, 0, RT, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("rt_ex",     0, 0, RT, 0, 1, 4'd6, ALUSRCA | ao(2'b10));
        applyStimulus("rt_wb",     0, 0, RT, 0, 1, 4'd7, REGDST | REGWRITE | DONE);

        applyStimulus("beq1_fetch",  0, 0, BEQ, 1, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("beq1_decode", 0, 0, BEQ, 1, 1, 4'd1, sb(2'b11));
        applyStimulus("beq1_ex",     0, 0, BEQ, 1, 1, 4'd8, PCEN | ALUSRCA | ao(2'b01) | ps(2'b01) | DONE);
        applyStimulus("beq0_fetch",  0, 0, BEQ, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("beq0_decode", 0, 0, BEQ, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("beq0_ex",     0, 0, BEQ, 0, 1, 4'd8, ALUSRCA | ao(2'b01) | ps(2'b01) | DONE);

        applyStimulus("j_fetch",  0, 0, JMP, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("j_decode", 0, 0, JMP, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("j_ex",     0, 0, JMP, 0, 1, 4'd11, PCEN | ps(2'b10) | DONE);

        applyStimulus("addi_fetch",  0, 0, ADDI, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("addi_decode", 0, 0, ADDI, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("addi_ex",     0, 0, ADDI, 0, 1, 4'd9, ALUSRCA | sb(2'b10) | ao(2'b11));
        applyStimulus("addi_wb",     0, 0, ADDI, 0, 1, 4'd10, REGWRITE | DONE);

        applyStimulus("bad_fetch",  0, 0, BAD, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("bad_decode", 0, 0, BAD, 0, 1, 4'd1, sb(2'b11) | ILLEGAL);

        applyStimulus("rstmid_fetch",  0, 0, SW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("rstmid_decode", 0, 0, SW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("rstmid_memadr", 0, 0, SW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        applyStimulus("rstmid_memwr",  0, 0, SW, 0, 0, 4'd5, IORD | MEMWRITE);
        applyStimulus("rstmid_rst0",   1, 0, SW, 0, 0, 4'd0, 17'h0);
        applyStimulus("rstmid_rst1",   1, 0, SW, 0, 1, 4'd0, 17'h0);

        applyStimulus("rw_fetch",  0, 0, LW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("rw_decode", 0, 0, LW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("rw_memadr", 0, 0, LW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        for (int i = 0; i < 4; i++)
            applyStimulus("rw_stall", 0, 0, LW, 0, 0, 4'd3, IORD);
        applyStimulus("rw_ready_wins", 0, 0, LW, 0, 1, 4'd3, IORD);
        applyStimulus("rw_memwb",      0, 0, LW, 0, 1, 4'd4, MEMTOREG | REGWRITE | DONE);

        applyStimulus("to_fetch",  0, 0, LW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("to_decode", 0, 0, LW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("to_memadr", 0, 0, LW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        for (int i = 0; i < 4; i++)
            applyStimulus("to_stall", 0, 0, LW, 0, 0, 4'd3, IORD);
        applyStimulus("to_expire",   0, 0, LW, 0, 0, 4'd3, IORD | MEMERR);
        applyStimulus("to_refetch",  0, 0, LW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));

        applyStimulus("noto_reset",  1, 1, LW, 0, 0, 4'd0, 17'h0);
        applyStimulus("noto_fetch",  0, 1, LW, 0, 1, 4'd0, PCEN | IRWRITE | sb(2'b01));
        applyStimulus("noto_decode", 0, 1, LW, 0, 1, 4'd1, sb(2'b11));
        applyStimulus("noto_memadr", 0, 1, LW, 0, 1, 4'd2, ALUSRCA | sb(2'b10));
        for (int i = 0; i < 300; i++)
            applyStimulus("noto_wait", 0, 1, LW, 0, 0, 4'd3, IORD);
        applyStimulus("noto_ready", 0, 1, LW, 0, 1, 4'd3, IORD);
        applyStimulus("noto_memwb", 0, 1, LW, 0, 1, 4'd4, MEMTOREG | REGWRITE | DONE);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending checks, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle main controller for the MIPS core; it replaces the single-cycle main decoder.
- Moore FSM sequences fetch, decode, execute, memory and writeback over a shared ALU and a unified instruction/data memory.
- Emits aluop (00 add, 01 sub, 10 funct, 11 addi) to the existing ALU decoder, plus all mux selects and write enables.
- Stalls on a memory ready handshake, with a watchdog on memory waits.

Parameters:
MEM_TIMEOUT, 15, max stall cycles waiting for mem_ready in a memory state; 0 disables the watchdog (wait forever); legal range 0..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
op  input  6  instr[31:26] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes access this cycle
pcen  output  1  PC register enable = pcwrite | (branch & zero)
iord  output  1  memory address select: 0 PC, 1 ALUOut
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regdst  output  1  1 rd, 0 rt
memtoreg  output  1  1 data register, 0 ALUOut
regwrite  output  1  register file write
alusrca  output  1  0 PC, 1 rs
alusrcb  output  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
pcsrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target
aluop  output  2  to ALU decoder
instr_done  output  1  one-cycle pulse when an instruction retires
illegal_op  output  1  one-cycle pulse on unsupported opcode in DECODE
mem_err  output  1  one-cycle pulse on watchdog expiry
state  output  4  current state code, for debug

Behaviour:
- State codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
  - Codes 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- rst asserted: state = FETCH immediately, wait counter = 0, and every output is forced to 0 (including alusrcb/aluop = 00) for as long as rst is high. Reset mid-instruction abandons it with no writes.
- Outputs are decoded from the registered state only, except mem_ready/zero qualification. Any output not listed for a state is 0.
- FETCH: alusrcb=01, aluop=00, irwrite=mem_ready, pcwrite=mem_ready. Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: alusrcb=11, aluop=00. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JEX
  - any other op -> FETCH, with illegal_op=1 this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: memtoreg=1, regwrite=1, instr_done=1. Next: FETCH.
- MEMWR: iord=1, memwrite=1 held through the stall. Exit to FETCH on mem_ready, with instr_done=1 in that exit cycle.
- RTYPEEX: alusrca=1, aluop=10. Next: RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1, instr_done=1. Next: FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1, instr_done=1. Next: FETCH. pcen follows zero combinationally.
- ADDIEX: alusrca=1, alusrcb=10, aluop=11. Next: ADDIWB.
- ADDIWB: regwrite=1, instr_done=1. Next: FETCH.
- JEX: pcsrc=10, pcwrite=1, instr_done=1. Next: FETCH.
- Watchdog (FETCH, MEMRD, MEMWR):
  - An 8-bit wait counter clears on entry to these states and whenever mem_ready=1.
  - It increments each cycle with mem_ready=0, saturating at 255.
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT with mem_ready still 0: mem_err=1 this cycle, all write enables forced 0 this cycle, next state FETCH, counter cleared.
  - mem_ready=1 in the same cycle as expiry means ready wins: no error.

Test Plan:
1. rst high mid-MEMWR (memwrite=1) -> state=0 and all outputs 0 the same cycle; after release, FETCH with mem_ready=1 gives pcen=1, irwrite=1.
2. lw (op 100011), mem_ready always 1 -> states 0,1,2,3,4,0; regwrite and memtoreg=1 only in state 4; instr_done one pulse; 5 cycles total.
3. sw with mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, one instr_done, no regwrite; R-type -> 0,1,6,7 with aluop=10 in 6 and regdst=1 in 7.
4. beq with zero=1 -> pcen=1, pcsrc=01 in state 8; repeat with zero=0 -> pcen=0; j -> pcsrc=10, pcen=1 in state 11.
5. op 111111 -> illegal_op pulse in DECODE, next state FETCH, no write enable asserted.
6. MEM_TIMEOUT=4, mem_ready held 0 in MEMRD -> mem_err pulse on the 5th waiting cycle, then FETCH, no regwrite; MEM_TIMEOUT=0 -> stays in MEMRD 300 cycles with no mem_err.
